// File: rtl/gpu_video_pkg.sv
// Shared video definitions for the GPU framebuffer path: 640x480@60 timing and pixel helpers.
package gpu_video_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Per-pixel control bits that travel alongside the BRAM read.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic sof;
  } vid_ctl_t;

  function automatic logic [23:0] rgb332_to_rgb888(input logic [7:0] pix);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = pix[7:5];
    g = pix[4:2];
    b = pix[1:0];
    return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster h/v counters with per-pixel active/sync/start-of-frame flags, held at origin
// while scanning is disabled.
module video_timing_gen
  import gpu_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     scan_en,
  output vid_ctl_t ctl,
  output logic     origin_next
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic          run_q, run_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  vid_ctl_t      ctl_d;

  // The first enabled cycle only arms run_q, so pixel (0,0) is always the first one emitted.
  always_comb begin
    run_d = scan_en;
    h_d   = '0;
    v_d   = '0;
    if (scan_en && run_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
        v_d = v_q;
      end
    end
    ctl_d.active = run_d && (h_d < H_ACT) && (v_d < V_ACT);
    ctl_d.hs     = run_d && (h_d >= HS_BEG) && (h_d < HS_END);
    ctl_d.vs     = run_d && (v_d >= VS_BEG) && (v_d < VS_END);
    ctl_d.sof    = ctl_d.active && (h_d == '0) && (v_d == '0);
    origin_next  = (h_d == '0) && (v_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      h_q   <= '0;
      v_q   <= '0;
      ctl   <= '0;
    end else begin
      run_q <= run_d;
      h_q   <= h_d;
      v_q   <= v_d;
      ctl   <= ctl_d;
    end
  end

endmodule

// File: rtl/fbuf_scanout.sv
// Framebuffer scan-out: raster BRAM reads, control delayed to match read latency,
// RGB332 to RGB888 expansion and registered video outputs.
module fbuf_scanout
  import gpu_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE        = VGA_H_ACTIVE,
  parameter int unsigned H_FP            = VGA_H_FP,
  parameter int unsigned H_SYNC          = VGA_H_SYNC,
  parameter int unsigned H_BP            = VGA_H_BP,
  parameter int unsigned V_ACTIVE        = VGA_V_ACTIVE,
  parameter int unsigned V_FP            = VGA_V_FP,
  parameter int unsigned V_SYNC          = VGA_V_SYNC,
  parameter int unsigned V_BP            = VGA_V_BP,
  parameter bit          HSYNC_POL       = 1'b0,
  parameter bit          VSYNC_POL       = 1'b0,
  parameter int unsigned FBUF_ADDR_WIDTH = 19,
  parameter int unsigned FBUF_DATA_WIDTH = 8,
  parameter int unsigned BRAM_LATENCY    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       scan_en,
  input  logic                       blank_req_n,
  output logic                       fbuf_en_rd,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr_rd,
  input  logic [FBUF_DATA_WIDTH-1:0] fbuf_rd_data,
  output logic                       vid_hsync,
  output logic                       vid_vsync,
  output logic                       vid_de,
  output logic [23:0]                vid_rgb,
  output logic                       frame_start
);

  vid_ctl_t                   ctl;
  logic                       origin_next;
  logic [FBUF_ADDR_WIDTH-1:0] addr_q;
  vid_ctl_t                   pipe_q [BRAM_LATENCY];
  vid_ctl_t                   tap;

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .scan_en     (scan_en),
    .ctl         (ctl),
    .origin_next (origin_next)
  );

  // Running raster address; it sits on the next pixel's address through blanking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else if (origin_next) begin
      addr_q <= '0;
    end else if (ctl.active) begin
      addr_q <= addr_q + 1'b1;
    end
  end

  assign fbuf_en_rd   = ctl.active;
  assign fbuf_addr_rd = addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BRAM_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= ctl;
      for (int i = 1; i < BRAM_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tap = pipe_q[BRAM_LATENCY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vid_de      <= 1'b0;
      vid_rgb     <= '0;
      vid_hsync   <= !HSYNC_POL;
      vid_vsync   <= !VSYNC_POL;
      frame_start <= 1'b0;
    end else begin
      vid_de      <= tap.active;
      vid_rgb     <= (tap.active && blank_req_n) ? rgb332_to_rgb888(fbuf_rd_data[7:0]) : '0;
      vid_hsync   <= tap.hs ? HSYNC_POL : !HSYNC_POL;
      vid_vsync   <= tap.vs ? VSYNC_POL : !VSYNC_POL;
      frame_start <= tap.sof;
    end
  end

endmodule
